// File: rtl/grid_walk_pkg.sv
// Shared encodings for the grid walker: move directions and walker FSM states.
package grid_walk_pkg;

  localparam logic [1:0] DIR_POS_X = 2'b00;
  localparam logic [1:0] DIR_NEG_X = 2'b01;
  localparam logic [1:0] DIR_NEG_Y = 2'b10;
  localparam logic [1:0] DIR_POS_Y = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Directions 00/01 move x, 10/11 move y.
  function automatic logic dir_is_x(input logic [1:0] dir);
    return ~dir[1];
  endfunction

endpackage

// File: rtl/grid_axis_stepper.sv
// One-axis next-coordinate logic with bound check against [0, max].
// GRID_WALK_WRAP_EN: wrap at the bounds instead of blocking the step.
module grid_axis_stepper
  import grid_walk_pkg::*;
#(
  parameter int unsigned COORD_W = 4
) (
  input  logic [COORD_W-1:0] coord,
  input  logic               dir_pos,
  input  logic               enable,
  input  logic [COORD_W-1:0] max,
  output logic [COORD_W-1:0] next_coord,
  output logic               blocked
);

  localparam int unsigned EXT_W = COORD_W + 1;

  logic [EXT_W-1:0] inc_c;
  logic [EXT_W-1:0] dec_c;
  logic             over_c;
  logic             under_c;

  // One extra bit so overflow past max and underflow below 0 are both visible.
  assign inc_c   = EXT_W'(coord) + EXT_W'(1);
  assign dec_c   = EXT_W'(coord) - EXT_W'(1);
  assign over_c  = inc_c > EXT_W'(max);
  assign under_c = dec_c[COORD_W];

  always_comb begin
    next_coord = coord;
    blocked    = 1'b0;
    if (enable) begin
      if (dir_pos) begin
        if (!over_c) begin
          next_coord = inc_c[COORD_W-1:0];
        end else begin
`ifdef GRID_WALK_WRAP_EN
          next_coord = '0;
`else
          blocked = 1'b1;
`endif
        end
      end else begin
        if (!under_c) begin
          next_coord = dec_c[COORD_W-1:0];
        end else begin
`ifdef GRID_WALK_WRAP_EN
          next_coord = max;
`else
          blocked = 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/grid_walker_param.sv
// Rotary-command grid walker: latches {distance, direction} on a rising command edge
// and steps one unit per clock. GRID_WALK_WRAP_EN selects wrap-around at the bounds.
module grid_walker_param
  import grid_walk_pkg::*;
#(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned DIST_W  = 2,
  parameter int unsigned MAX_X   = (1 << COORD_W) - 1,
  parameter int unsigned MAX_Y   = (1 << COORD_W) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIST_W+1:0]  Y,
  input  logic               rotation_event,
  output logic [COORD_W-1:0] final_x,
  output logic [COORD_W-1:0] final_y,
  output logic               busy,
  output logic               done,
  output logic               hit_wall,
  output logic               cmd_dropped
);

  state_t             state;
  logic [1:0]         dir;
  logic [DIST_W-1:0]  remaining;
  logic               prev_rotation_event;

  logic               rot_edge_c;
  logic               x_en_c;
  logic               y_en_c;
  logic [COORD_W-1:0] next_x_c;
  logic [COORD_W-1:0] next_y_c;
  logic               x_blocked_c;
  logic               y_blocked_c;
  logic               blocked_c;

  assign rot_edge_c = rotation_event & ~prev_rotation_event;
  assign x_en_c     = (state == ST_STEP) &&  dir_is_x(dir);
  assign y_en_c     = (state == ST_STEP) && !dir_is_x(dir);
  assign blocked_c  = x_blocked_c | y_blocked_c;

  grid_axis_stepper #(.COORD_W(COORD_W)) u_x_stepper (
    .coord      (final_x),
    .dir_pos    (dir == DIR_POS_X),
    .enable     (x_en_c),
    .max        (COORD_W'(MAX_X)),
    .next_coord (next_x_c),
    .blocked    (x_blocked_c)
  );

  grid_axis_stepper #(.COORD_W(COORD_W)) u_y_stepper (
    .coord      (final_y),
    .dir_pos    (dir == DIR_POS_Y),
    .enable     (y_en_c),
    .max        (COORD_W'(MAX_Y)),
    .next_coord (next_y_c),
    .blocked    (y_blocked_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      dir                 <= DIR_POS_X;
      remaining           <= '0;
      prev_rotation_event <= 1'b0;
      final_x             <= '0;
      final_y             <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      hit_wall            <= 1'b0;
      cmd_dropped         <= 1'b0;
    end else begin
      prev_rotation_event <= rotation_event;
      done                <= 1'b0;
      cmd_dropped         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rot_edge_c) begin
            dir       <= Y[1:0];
            remaining <= Y[DIST_W+1:2];
            hit_wall  <= 1'b0;
            if (Y[DIST_W+1:2] == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_STEP;
              busy  <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          cmd_dropped <= rot_edge_c;
          // A blocked step holds position and ends the command early.
          if (blocked_c) begin
            hit_wall <= 1'b1;
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            final_x   <= next_x_c;
            final_y   <= next_y_c;
            remaining <= remaining - DIST_W'(1);
            if (remaining == DIST_W'(1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          cmd_dropped <= rot_edge_c;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
